jpeg_coef_zigzag_buf: RTL and testbench

- Sink-side companion to the JPEG front end (RGB→YCbCr→8x8 DCT).
- Accepts the three-channel DCT coefficient stream in raster order, 64 coefficients per block.
- Stores each block in a ping-pong buffer and re-emits it in JPEG zig-zag order over a valid/ready interface, ready for the quantiser/entropy coder.
- Decouples the DCT's push-only output from a back-pressuring downstream.

---
 rtl/jpeg_coef_zigzag_buf.sv | 223 ++++++++++++++++++++++
 tb/tb_jpeg_coef_zigzag_buf.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_coef_zigzag_buf.sv
// jpeg_coef_zigzag_buf
//   Ping-pong coefficient buffer placed after the JPEG 8x8 DCT. Raster-order
//   Y/Cb/Cr coefficient triples are written into one of two 64-entry banks.
//   Each full bank is re-emitted in JPEG zig-zag order over a valid/ready
//   interface. The DCT side only pushes data, and the buffer absorbs
//   back-pressure from the quantiser/entropy coder.
//
//   Build option: define JPEG_ZZBUF_OVF_EN to add the sticky err_ovf output.
//   err_ovf flags writes that were dropped because in_ready was low.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready write handshake; in_ready = current write bank empty
//   in_Y/in_Cb/in_Cr  raster-order DCT coefficients (DATA_W, two's complement)
//   out_valid/out_ready read handshake
//   out_Y/out_Cb/out_Cr zig-zag-order coefficients (registered)
//   out_idx           zig-zag position of the current output beat
//   out_last          high on zig-zag position 63
//   block_done        one-cycle pulse after the 64th write of a block
//   err_ovf           sticky dropped-write flag (JPEG_ZZBUF_OVF_EN only)

module jpeg_coef_zigzag_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_Y,
    input  logic [DATA_W-1:0] in_Cb,
    input  logic [DATA_W-1:0] in_Cr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_Y,
    output logic [DATA_W-1:0] out_Cb,
    output logic [DATA_W-1:0] out_Cr,
    output logic [5:0]        out_idx,
    output logic              out_last,
    output logic              block_done
`ifdef JPEG_ZZBUF_OVF_EN
    ,
    output logic              err_ovf
`endif
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    // Zig-zag position -> raster address
    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Bank b occupies addresses {b, raster[5:0]}
    logic [DATA_W-1:0] mem_y  [0:127];
    logic [DATA_W-1:0] mem_cb [0:127];
    logic [DATA_W-1:0] mem_cr [0:127];

    state_t      state;
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic        wr_bank;
    logic        rd_bank;
    logic        rd_other;
    logic [5:0]  wr_cnt;
    logic [5:0]  rd_cnt;

    logic        wr_fire;
    logic        wr_done;
    logic        rd_free;
    logic        rd_sel_bank;
    logic [5:0]  rd_sel_pos;
    logic [6:0]  rd_addr;

    assign in_ready = ~full[wr_bank];
    assign wr_fire  = in_valid & in_ready;
    assign wr_done  = wr_fire & (wr_cnt == 6'd63);
    assign rd_free  = out_valid & out_ready & out_last;
    assign rd_other = ~rd_bank;

    // Read address for the next output-register load. When the last beat is
    // accepted, the load targets element 0 of the other bank. This keeps
    // streaming without a bubble when that bank is already full.
    always_comb begin
        rd_sel_bank = rd_bank;
        rd_sel_pos  = rd_cnt;
        if (state == S_IDLE) begin
            rd_sel_pos = '0;
        end else if (rd_free) begin
            rd_sel_bank = rd_other;
            rd_sel_pos  = '0;
        end
        rd_addr = {rd_sel_bank, ZZ[rd_sel_pos]};
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_y[{wr_bank, wr_cnt}]  <= in_Y;
            mem_cb[{wr_bank, wr_cnt}] <= in_Cb;
            mem_cr[{wr_bank, wr_cnt}] <= in_Cr;
        end
    end

    // The writer only fills an empty bank and the reader only frees a full
    // one, so the two updates never touch the same bank in one cycle.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_free) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            full <= full_nxt;
        end
    end

    // Write side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= wr_done;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Read FSM with registered outputs. rd_cnt is the zig-zag position that
    // the next load will fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            out_Y     <= '0;
            out_Cb    <= '0;
            out_Cr    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (full[rd_bank]) begin
                        state     <= S_STREAM;
                        out_valid <= 1'b1;
                        out_Y     <= mem_y[rd_addr];
                        out_Cb    <= mem_cb[rd_addr];
                        out_Cr    <= mem_cr[rd_addr];
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        rd_cnt    <= 6'd1;
                    end
                end
                S_STREAM: begin
                    if (!out_valid || out_ready) begin
                        if (rd_free) begin
                            rd_bank <= rd_other;
                            if (full[rd_other]) begin
                                out_valid <= 1'b1;
                                out_Y     <= mem_y[rd_addr];
                                out_Cb    <= mem_cb[rd_addr];
                                out_Cr    <= mem_cr[rd_addr];
                                out_idx   <= '0;
                                out_last  <= 1'b0;
                                rd_cnt    <= 6'd1;
                            end else begin
                                out_valid <= 1'b0;
                                rd_cnt    <= '0;
                                state     <= S_IDLE;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_Y     <= mem_y[rd_addr];
                            out_Cb    <= mem_cb[rd_addr];
                            out_Cr    <= mem_cr[rd_addr];
                            out_idx   <= rd_cnt;
                            out_last  <= (rd_cnt == 6'd63);
                            rd_cnt    <= rd_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JPEG_ZZBUF_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
        end else if (in_valid && !in_ready) begin
            err_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_coef_zigzag_buf.sv
// Testbench for jpeg_coef_zigzag_buf. The reference model keeps blocks in
// arrays and builds the zig-zag order by walking the anti-diagonals.
// It also keeps a count of buffered full blocks to predict in_ready.

module tb_jpeg_coef_zigzag_buf;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] y;
        logic [DW-1:0] cb;
        logic [DW-1:0] cr;
        logic [5:0]    idx;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_Y = '0;
    logic [DW-1:0] in_Cb = '0;
    logic [DW-1:0] in_Cr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_Y;
    logic [DW-1:0] out_Cb;
    logic [DW-1:0] out_Cr;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          block_done;
`ifdef JPEG_ZZBUF_OVF_EN
    logic          err_ovf;
`endif

    always #5 clk = ~clk;

    jpeg_coef_zigzag_buf #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_Y       (in_Y),
        .in_Cb      (in_Cb),
        .in_Cr      (in_Cr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_Y      (out_Y),
        .out_Cb     (out_Cb),
        .out_Cr     (out_Cr),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .block_done (block_done)
`ifdef JPEG_ZZBUF_OVF_EN
        ,
        .err_ovf    (err_ovf)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    int            zz_m [64];
    beat_t         exp_q [$];
    beat_t         src_q [$];
    logic [DW-1:0] blk_y [64];
    logic [DW-1:0] blk_cb [64];
    logic [DW-1:0] blk_cr [64];
    int            blk_cnt;
    int            nfull;
    logic          exp_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        src_q.delete();
        blk_cnt = 0;
        nfull   = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_Y"}, out_Y, 0);
        chk({tag, "_out_Cb"}, out_Cb, 0);
        chk({tag, "_out_Cr"}, out_Cr, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_block_done"}, block_done, 0);
`ifdef JPEG_ZZBUF_OVF_EN
        chk({tag, "_err_ovf"}, err_ovf, 0);
`endif
    endtask

    // One clock cycle: drive, check pre-edge handshake, advance, update model.
    task automatic cycle(input logic v, input logic [DW-1:0] y, input logic [DW-1:0] cb,
                         input logic [DW-1:0] cr, input logic ordy, output logic wacc);
        logic          oacc;
        logic          last_acc;
        logic          done;
        logic          hv;
        int            nf_pre;
        beat_t         e;
        logic [DW-1:0] hy, hcb, hcr;
        logic [5:0]    hidx;
        logic          hlast;
        in_valid  = v;
        in_Y      = y;
        in_Cb     = cb;
        in_Cr     = cr;
        out_ready = ordy;
        chk("in_ready", in_ready, (nfull < 2));
        wacc = v && (nfull < 2);
        if (v && nfull >= 2) exp_ovf = 1'b1;
        oacc     = out_valid && ordy;
        last_acc = 1'b0;
        if (oacc) begin
            if (exp_q.size() == 0) begin
                chk("beat_expected", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_Y", out_Y, e.y);
                chk("out_Cb", out_Cb, e.cb);
                chk("out_Cr", out_Cr, e.cr);
                chk("out_idx", out_idx, e.idx);
                chk("out_last", out_last, (e.idx == 6'd63));
                last_acc = (e.idx == 6'd63);
            end
        end
        nf_pre = nfull;
        hv     = out_valid && !ordy;
        hy = out_Y; hcb = out_Cb; hcr = out_Cr; hidx = out_idx; hlast = out_last;
        @(posedge clk);
        #1;
        done = 1'b0;
        if (wacc) begin
            blk_y[blk_cnt]  = y;
            blk_cb[blk_cnt] = cb;
            blk_cr[blk_cnt] = cr;
            blk_cnt++;
            if (blk_cnt == 64) begin
                for (int p = 0; p < 64; p++) begin
                    e.y   = blk_y[zz_m[p]];
                    e.cb  = blk_cb[zz_m[p]];
                    e.cr  = blk_cr[zz_m[p]];
                    e.idx = 6'(p);
                    exp_q.push_back(e);
                end
                blk_cnt = 0;
                nfull++;
                done = 1'b1;
            end
        end
        if (last_acc) begin
            nfull--;
            // A block that was already full continues without a bubble; otherwise the stream pauses.
            chk("after_last_valid", out_valid, (nf_pre == 2));
        end
        if (hv) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_Y", out_Y, hy);
            chk("hold_Cb", out_Cb, hcb);
            chk("hold_Cr", out_Cr, hcr);
            chk("hold_idx", out_idx, hidx);
            chk("hold_last", out_last, hlast);
        end
        chk("block_done", block_done, done);
`ifdef JPEG_ZZBUF_OVF_EN
        chk("err_ovf", err_ovf, exp_ovf);
`endif
    endtask

    // Feed src_q and drain outputs. rmode: 0 ready high, 1 ready low, 2 random with 10-cycle stalls.
    task automatic run(input int budget, input int vprob, input int rmode, input bit src_only);
        int   n;
        int   stall;
        logic v, r, acc;
        beat_t s;
        n = 0;
        stall = 0;
        while (n < budget && (src_q.size() > 0 || (!src_only && exp_q.size() > 0))) begin
            v = (src_q.size() > 0) && ($urandom_range(1, 100) <= vprob);
            if (src_q.size() > 0) s = src_q[0];
            else begin s.y = DW'($urandom); s.cb = DW'($urandom); s.cr = DW'($urandom); s.idx = '0; end
            case (rmode)
                0: r = 1'b1;
                1: r = 1'b0;
                default: begin
                    if (stall > 0) begin r = 1'b0; stall--; end
                    else if ($urandom_range(0, 15) == 0) begin r = 1'b0; stall = 9; end
                    else r = 1'($urandom_range(0, 1));
                end
            endcase
            cycle(v, s.y, s.cb, s.cr, r, acc);
            if (acc) void'(src_q.pop_front());
            n++;
        end
        chk("run_complete", src_q.size() + (src_only ? 0 : exp_q.size()), 0);
    endtask

    task automatic push_random_blocks(input int nblk);
        beat_t s;
        for (int i = 0; i < nblk * 64; i++) begin
            s.y  = DW'($urandom) & 16'h7FFE;
            s.cb = DW'($urandom);
            s.cr = DW'($urandom);
            s.idx = '0;
            src_q.push_back(s);
        end
    endtask

    initial begin
        int    p;
        int    rlo, rhi;
        logic  acc;
        beat_t s;

        // Reference zig-zag: walk the anti-diagonals; even sums run bottom-left to top-right.
        p = 0;
        for (int d = 0; d < 15; d++) begin
            rlo = (d > 7) ? d - 7 : 0;
            rhi = (d < 8) ? d : 7;
            if (d % 2 == 0) begin
                for (int r = rhi; r >= rlo; r--) begin zz_m[p] = r * 8 + (d - r); p++; end
            end else begin
                for (int r = rlo; r <= rhi; r++) begin zz_m[p] = r * 8 + (d - r); p++; end
            end
        end
        model_reset();

        // Reset values
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single ramp block, first-beat latency, zig-zag order
        for (int k = 0; k < 64; k++) begin
            cycle(1'b1, DW'(k), DW'(k + 100), DW'(-k), 1'b1, acc);
        end
        chk("first_latency_idle", out_valid, 0);
        cycle(1'b0, '0, '0, '0, 1'b1, acc);
        chk("first_latency_valid", out_valid, 1);
        chk("first_beat_Y", out_Y, 0);
        run(200, 0, 0, 1'b0);

        // Three back-to-back blocks, continuous input, ready high
        push_random_blocks(3);
        run(600, 100, 0, 1'b0);

        // Random back-pressure with long stalls
        push_random_blocks(3);
        run(4000, 70, 2, 1'b0);

        // Overflow: both banks full, ready low, then 0x7FFF writes are dropped
        push_random_blocks(2);
        run(400, 100, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, acc);
            chk("ovf_dropped", acc, 0);
        end
        run(600, 0, 0, 1'b0);

        // Reset at readout beat 20 with the second bank full
        push_random_blocks(2);
        run(400, 100, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, acc);
        end
        chk("pre_reset_idx", out_idx, 20);
        rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Fresh block with signed extremes at raster 0 and 63
        for (int i = 0; i < 64; i++) begin
            s.y  = (i == 0 || i == 63) ? 16'h8000 : DW'($urandom);
            s.cb = (i == 0 || i == 63) ? 16'h7FFF : DW'($urandom);
            s.cr = DW'($urandom);
            s.idx = '0;
            src_q.push_back(s);
        end
        run(400, 100, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
